adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001: Parameter WIDTH, default 32, operand and result width in bits.
REQ-002: Requester count SHALL be fixed at 4; requesters are indexed 0..3.
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: req  input  4  req[i] high = requester i wants one addition.
REQ-006: a_bus  input  4*WIDTH  operand A; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-007: b_bus  input  4*WIDTH  operand B; same slicing as a_bus.
REQ-008: ack  output  4  one-hot, one-cycle pulse; ack[i] = requester i's result is on res.
REQ-009: res  output  WIDTH  registered sum of the granted requester's operands.
REQ-010: gnt_id  output  2  index of the requester currently owning the adder.
REQ-011: busy  output  1  high in EXEC and RESP states.
REQ-012: ovf  output  1  signed-overflow flag for res; see Configuration.

Function
REQ-013: Block SHALL share one WIDTH-bit adder among 4 requesters using a 3-state FSM: IDLE, EXEC, RESP.
REQ-014: IDLE, req==0: stay in IDLE; outputs hold.
REQ-015: IDLE, req!=0: pick winner k by round-robin from pointer ptr, checking ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Latch a/b slices of k into operand registers.
  - Set gnt_id=k.
  - Go to EXEC.
REQ-016: EXEC: register res = (opA + opB) mod 2^WIDTH, carry discarded; set ack[gnt_id]=1; go to RESP.
REQ-017: RESP: ack stays high this cycle only; next edge clears ack, sets ptr=(gnt_id+1) mod 4, returns to IDLE.
REQ-018: Latency SHALL be 2 cycles from the edge that samples req in IDLE to the edge that raises ack; throughput SHALL be one addition per 3 cycles.
REQ-019: res and gnt_id SHALL hold their values after RESP until the next EXEC/grant updates them.
REQ-020: Requester i SHALL hold req[i] and its operands stable until it samples ack[i] high, then drop req[i] on that same edge.
REQ-021: req[i] still high in IDLE after its ack SHALL be treated as a new request.
REQ-022: Operands SHALL be sampled only at the grant edge; later changes, or req withdrawal in EXEC/RESP, SHALL NOT affect the in-flight result, and its ack SHALL still pulse.
REQ-023: Simultaneous requests SHALL be served in round-robin order; no requester waits more than 3 other grants.
REQ-024: ack SHALL never have more than one bit set.

Reset
REQ-025: rst_n low SHALL immediately and asynchronously force:
  - state=IDLE, ptr=0, ack=0, res=0, gnt_id=0, busy=0, ovf=0
  - operand registers=0
REQ-026: Reset during EXEC or RESP SHALL abort the operation with no ack pulse; the first grant after reset SHALL use ptr=0.

Configuration
REQ-027: Macro ADDER_ARB_OVF_EN defined: ovf SHALL be registered with res in EXEC and hold with res.
  - ovf = 1 when opA and opB have the same sign bit and res's sign bit differs.
REQ-028: ADDER_ARB_OVF_EN undefined: ovf port SHALL remain present and tied to 0; no overflow logic is synthesized.

Verification
REQ-029: Reset, then req=4'b0100, a2=5, b2=7 -> two edges later ack=4'b0100, res=12, gnt_id=2; ack low the following cycle.
REQ-030: req=4'b1111 held, each requester dropping on its ack, ptr=0 -> acks in order 0,1,2,3, each spaced 3 cycles apart.
REQ-031: WIDTH=32, a=32'hFFFFFFFF, b=1 -> res=0.
  - With ADDER_ARB_OVF_EN: ovf=0.
  - a=32'h7FFFFFFF, b=1 -> res=32'h80000000; ovf=1 with macro, ovf=0 without.
REQ-032: Grant requester 1, change a1 and drop req[1] during EXEC -> ack[1] still pulses with the originally latched sum.
REQ-033: Assert rst_n low mid-EXEC -> ack never pulses, all outputs 0 at once; after release, req=4'b1010 grants requester 1 first.

Source files
------------

// File: rtl/adder_arbiter.sv
// Four-way round-robin arbiter sharing one WIDTH-bit adder through an IDLE -> EXEC -> RESP FSM.
// Optional macro ADDER_ARB_OVF_EN registers a signed-overflow flag together with res.

module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_bus,
  input  logic [4*WIDTH-1:0] b_bus,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   res,
  output logic [1:0]         gnt_id,
  output logic               busy,
  output logic               ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [3:0]              ack_q, ack_d;
  logic signed [WIDTH-1:0] opa_q, opa_d;
  logic signed [WIDTH-1:0] opb_q, opb_d;
  logic signed [WIDTH-1:0] res_q, res_d;

  logic [7:0]              req_dbl;
  logic [3:0]              req_rot;
  logic [1:0]              win;
  logic                    win_vld;
  logic signed [WIDTH-1:0] a_sel;
  logic signed [WIDTH-1:0] b_sel;
  logic signed [WIDTH-1:0] sum;

  // Rotate requests so bit 0 is the requester the pointer favours most.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr_q +: 4];
  assign win_vld = |req;

  always_comb begin
    win = ptr_q;
    for (int j = 3; j >= 0; j--) begin
      if (req_rot[j]) win = ptr_q + j[1:0];
    end
  end

  assign a_sel = a_bus[int'(win)*WIDTH +: WIDTH];
  assign b_sel = b_bus[int'(win)*WIDTH +: WIDTH];

  // The single shared adder; carry out is dropped.
  assign sum = opa_q + opb_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = 4'b0000;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          opa_d   = a_sel;
          opb_d   = b_sel;
          gnt_d   = win;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = sum;
        ack_d   = 4'b0001 << gnt_q;
        state_d = RESP;
      end
      RESP: begin
        ptr_d   = gnt_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 2'd0;
      ack_q   <= 4'b0000;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

`ifdef ADDER_ARB_OVF_EN
  // Overflow: operands agree in sign but the wrapped sum does not.
  function automatic logic ovf_calc(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == EXEC) begin
      ovf_q <= ovf_calc(opa_q, opb_q, sum);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign ack    = ack_q;
  assign res    = res_q;
  assign gnt_id = gnt_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed vectors push expected acks, a forked monitor pops them.

module tb_adder_arbiter;

  localparam int W = 32;
`ifdef ADDER_ARB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] a_bus;
  logic [4*W-1:0] b_bus;
  logic [3:0]     ack;
  logic [W-1:0]   res;
  logic [1:0]     gnt_id;
  logic           busy;
  logic           ovf;

  adder_arbiter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a_bus  (a_bus),
    .b_bus  (b_bus),
    .ack    (ack),
    .res    (res),
    .gnt_id (gnt_id),
    .busy   (busy),
    .ovf    (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic auto_drop = 1'b0;
  logic [3:0] ack_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [W-1:0] sum, input logic o, input int c);
    exp_t e;
    e.id = id; e.sum = sum; e.ovf = o; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
  endtask

  // One clock: requesters that saw their ack drop req on the following edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ack_l = ack;
      @(posedge clk);
      #1;
      if (auto_drop) req = req & ~ack_l;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"},  ack,    0);
    chk({tag, "_res"},  res,    0);
    chk({tag, "_gnt"},  gnt_id, 0);
    chk({tag, "_busy"}, busy,   0);
    chk({tag, "_ovf"},  ovf,    0);
  endtask

  initial begin
    int c;
    exp_t e;
    rst_n = 1'b0;
    req   = 4'b0000;
    a_bus = '0;
    b_bus = '0;

    fork
      forever begin
        @(negedge clk);
        if (ack !== 4'b0000) begin
          chk("ack_onehot", $onehot(ack), 1);
          if (sb.size() == 0) begin
            chk("unexpected_ack", ack, 0);
          end else begin
            e = sb.pop_front();
            chk("ack_id",    ack,    4'b0001 << e.id);
            chk("res",       res,    e.sum);
            chk("gnt_id",    gnt_id, e.id);
            chk("ovf",       ovf,    e.ovf);
            chk("ack_cycle", cyc,    e.cyc);
          end
        end
      end
    join_none

    tick(2);
    chk_zero("reset");
    rst_n = 1'b1;
    tick(1);

    // Single request from requester 2.
    auto_drop = 1'b1;
    set_op(2, 32'd5, 32'd7);
    req = 4'b0100;
    c = cyc;
    push(2'd2, 32'd12, 1'b0, c + 2);
    tick(1);
    chk("exec_busy", busy, 1);
    chk("exec_gnt",  gnt_id, 2);
    chk("exec_ack",  ack, 0);
    tick(3);
    chk("hold_res",  res, 32'd12);
    chk("hold_gnt",  gnt_id, 2);
    chk("idle_busy", busy, 0);

    // Reset again so the pointer restarts at 0, then all four request at once.
    rst_n = 1'b0;
    #1;
    chk_zero("reset2");
    tick(1);
    rst_n = 1'b1;
    tick(1);
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
    set_op(1, 32'h7FFF_FFFF, 32'h0000_0001);
    set_op(2, 32'h8000_0000, 32'h8000_0000);
    set_op(3, 32'h0000_0003, 32'hFFFF_FFFE);
    req = 4'b1111;
    c = cyc;
    push(2'd0, 32'h0000_0000, 1'b0,   c + 2);
    push(2'd1, 32'h8000_0000, OVF_ON, c + 5);
    push(2'd2, 32'h0000_0000, OVF_ON, c + 8);
    push(2'd3, 32'h0000_0001, 1'b0,   c + 11);
    tick(14);

    // Requester 1 changes its operand and withdraws while in EXEC.
    set_op(1, 32'd100, 32'd23);
    req = 4'b0010;
    c = cyc;
    push(2'd1, 32'd123, 1'b0, c + 2);
    tick(1);
    set_op(1, 32'd999, 32'd23);
    req = 4'b0000;
    tick(4);

    // Reset mid-EXEC: no ack, outputs cleared immediately.
    set_op(0, 32'd1, 32'd1);
    req = 4'b0001;
    tick(1);
    chk("abort_busy", busy, 1);
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    chk_zero("async_rst");
    tick(2);
    rst_n = 1'b1;
    tick(1);
    set_op(1, 32'd10, 32'd20);
    set_op(3, 32'd40, 32'd2);
    req = 4'b1010;
    c = cyc;
    push(2'd1, 32'd30, 1'b0, c + 2);
    push(2'd3, 32'd42, 1'b0, c + 5);
    tick(10);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
